// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the pipe writeback stage
// and the mdu, with an age counter that bounds mdu starvation.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    output logic        pipe_ready,
    input  logic [4:0]  pipe_reg,
    input  logic [31:0] pipe_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_reg,
    input  logic [31:0] mdu_data,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData
);

    localparam logic       PIPE_PRI = 1'b0;
    localparam logic       MDU_PRI  = 1'b1;
    localparam logic [7:0] MAX_CNT  = 8'(MAX_WAIT);

    logic        state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic [4:0]  wr_q, wr_d;
    logic [31:0] wd_q, wd_d;

    logic mdu_pri;
    logic pipe_xfer;
    logic mdu_xfer;
    logic bump;

    // Reset forces pipe-priority ready rules regardless of the stored state.
    assign mdu_pri    = !reset && (state_q == MDU_PRI);
    assign pipe_ready = mdu_pri ? !mdu_valid : 1'b1;
    assign mdu_ready  = mdu_pri ? 1'b1 : !pipe_valid;

    assign pipe_xfer = pipe_valid && pipe_ready;
    assign mdu_xfer  = mdu_valid && mdu_ready;
    assign bump      = mdu_valid && !mdu_ready && (wait_cnt_q != MAX_CNT);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        state_d    = state_q;
        we_d       = 1'b0;
        wr_d       = wr_q;
        wd_d       = wd_q;

        if (!mdu_valid || mdu_xfer) begin
            wait_cnt_d = 8'd0;
        end else if (bump) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        case (state_q)
            PIPE_PRI: begin
                if (bump && (wait_cnt_q + 8'd1 == MAX_CNT)) begin
                    state_d = MDU_PRI;
                end
            end
            default: begin
                if (mdu_xfer || !mdu_valid) begin
                    state_d = PIPE_PRI;
                end
            end
        endcase

        // Register 0 grants are consumed here and never reach the regfile.
        unique case (1'b1)
            pipe_xfer && (pipe_reg != 5'd0): begin
                we_d = 1'b1;
                wr_d = pipe_reg;
                wd_d = pipe_data;
            end
            mdu_xfer && (mdu_reg != 5'd0): begin
                we_d = 1'b1;
                wr_d = mdu_reg;
                wd_d = mdu_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PIPE_PRI;
            wait_cnt_q <= 8'd0;
            we_q       <= 1'b0;
            wr_q       <= 5'd0;
            wd_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            wr_q       <= wr_d;
            wd_q       <= wd_d;
        end
    end

    // A write landing in a reset cycle is dropped before it reaches the regfile.
    assign RegWrite      = we_q && !reset;
    assign WriteRegister = wr_q;
    assign WriteData     = wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, checked against a consecutive-stall reference model.
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        bit          we;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_valid = 1'b0;
    logic        pipe_ready;
    logic [4:0]  pipe_reg = '0;
    logic [31:0] pipe_data = '0;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_reg = '0;
    logic [31:0] mdu_data = '0;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    exp_t sb[$];

    // Reference model: how long the mdu has been refused in a row,
    // plus the last value actually written to the register file port.
    int          stall = 0;
    logic [4:0]  last_r = '0;
    logic [31:0] last_d = '0;

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk),
        .reset(reset),
        .pipe_valid(pipe_valid),
        .pipe_ready(pipe_ready),
        .pipe_reg(pipe_reg),
        .pipe_data(pipe_data),
        .mdu_valid(mdu_valid),
        .mdu_ready(mdu_ready),
        .mdu_reg(mdu_reg),
        .mdu_data(mdu_data),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: registered outputs of this cycle answer the previous cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got 0 entries expected 1 at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("RegWrite", 32'(RegWrite), 32'(e.we && !reset));
                    chk("WriteRegister", 32'(WriteRegister), 32'(e.r));
                    chk("WriteData", WriteData, e.d);
                end
            end
        end
    end

    task automatic cycle(input logic pv, input logic [4:0] pr,
                         input logic [31:0] pd, input logic mv,
                         input logic [4:0] mr, input logic [31:0] md,
                         input logic rst, output bit pa, output bit ma);
        bit   forced;
        logic xp_pr, xp_mr;
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        pipe_valid = pv;
        pipe_reg = pr;
        pipe_data = pd;
        mdu_valid = mv;
        mdu_reg = mr;
        mdu_data = md;
        @(negedge clk);
        forced = !rst && (stall >= MAX_WAIT);
        xp_pr = forced ? !mv : 1'b1;
        xp_mr = forced ? 1'b1 : !pv;
        chk("pipe_ready", 32'(pipe_ready), 32'(xp_pr));
        chk("mdu_ready", 32'(mdu_ready), 32'(xp_mr));
        pa = pv && xp_pr && !rst;
        ma = mv && xp_mr && !rst;
        e.we = 1'b0;
        if (rst) begin
            stall = 0;
            last_r = '0;
            last_d = '0;
        end else begin
            if (!mv || ma) stall = 0;
            else stall++;
            if (pa && pr != 5'd0) begin
                e.we = 1'b1;
                last_r = pr;
                last_d = pd;
            end else if (ma && mr != 5'd0) begin
                e.we = 1'b1;
                last_r = mr;
                last_d = md;
            end
        end
        e.r = last_r;
        e.d = last_d;
        sb.push_back(e);
        mon_en = 1'b1;
    endtask

    initial begin
        bit pa, ma;
        bit ph, mh;
        bit rs;
        logic [4:0] prr, mrr;
        logic [31:0] pdd, mdd;

        // Reset two cycles with both requesters active.
        cycle(1, 5'd7, 32'h1, 1, 5'd8, 32'h2, 1, pa, ma);
        cycle(1, 5'd7, 32'h1, 1, 5'd8, 32'h2, 1, pa, ma);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, pa, ma);

        // Pipe alone.
        cycle(1, 5'd3, 32'h11, 0, 5'd0, 32'h0, 0, pa, ma);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, pa, ma);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, pa, ma);

        // Starvation: forced grant on the fifth stalled-or-granted cycle.
        for (int i = 0; i < 5; i++)
            cycle(1, 5'(i + 10), 32'(i), 1, 5'd5, 32'hDEADBEEF, 0, pa, ma);
        cycle(1, 5'd20, 32'h20, 0, 5'd0, 32'h0, 0, pa, ma);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, pa, ma);

        // Mdu alone.
        cycle(0, 5'd0, 32'h0, 1, 5'd9, 32'h12345678, 0, pa, ma);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, pa, ma);

        // Register 0 is accepted but never written.
        cycle(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 0, pa, ma);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, pa, ma);

        // Reset after 3 stalls; mdu then needs the full wait again.
        for (int i = 0; i < 3; i++)
            cycle(1, 5'd1, 32'(i), 1, 5'd6, 32'hCAFE0000, 0, pa, ma);
        cycle(1, 5'd1, 32'h9, 1, 5'd6, 32'hCAFE0000, 1, pa, ma);
        for (int i = 0; i < 5; i++)
            cycle(1, 5'd2, 32'(i), 1, 5'd6, 32'hCAFE0000, 0, pa, ma);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, pa, ma);

        // Random traffic with hold-until-accepted requesters.
        ph = 0;
        mh = 0;
        prr = '0; mrr = '0; pdd = '0; mdd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!ph && $urandom_range(9) < 7) begin
                ph = 1;
                prr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
                pdd = $urandom;
            end
            if (!mh && $urandom_range(9) < 4) begin
                mh = 1;
                mrr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
                mdd = $urandom;
            end
            rs = ($urandom_range(49) == 0);
            cycle(ph, prr, pdd, mh, mrr, mdd, rs, pa, ma);
            if (rs) begin
                ph = 0;
                mh = 0;
            end
            if (pa) ph = 0;
            if (ma) mh = 0;
        end
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, pa, ma);

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
